// File: rtl/core_data_arbiter_pkg.sv
// Shared types for the two-port data-memory arbiter: port IDs, lock states and the
// default in-flight read depth.
package core_data_arbiter_pkg;

  localparam int MAX_OUTST_DEF = 2;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_AUX  = 1'b1
  } port_id_e;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/core_data_arbiter_if.sv
// One req/gnt/rvalid memory port. Used for both requesters and for the memory side.
//
// Handshake: req (with wr/addr/wdata/be) is held stable until the cycle in which gnt
// is high; that cycle is the transfer. A read's data returns later, in order, as a
// single-cycle rvalid with rdata. Writes get no response.
interface core_data_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
);
  logic                  req;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_WIDTH-1:0]   be;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, wr, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, wr, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/core_data_arb_fifo.sv
// In-order FIFO of 1-bit port IDs, one entry per outstanding read.
module core_data_arb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push_id,
  input  logic                     pop,
  output logic                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem_q[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/core_data_arbiter.sv
// Shares one data-memory port between the core (port 0) and an aux master (port 1).
// Optional build macro DATA_ARB_FIXED_PRIO_EN: port 0 wins ties instead of round-robin.
module core_data_arbiter
  import core_data_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4,
  parameter int MAX_OUTST  = MAX_OUTST_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  core_data_arbiter_if.slave          m0,
  core_data_arbiter_if.slave          m1,
  core_data_arbiter_if.master         mem,
  output logic [$clog2(MAX_OUTST):0]  outst_cnt_o,
  output logic                        err_o,
  output lock_state_e                 lock_state_o
);
  lock_state_e lock_state;
  port_id_e    lock_id;
  port_id_e    sel;
  logic        elig0, elig1;
  logic        fifo_full, fifo_empty, fifo_head;
  logic        grant, push, pop;

  // A read can only be issued while a response slot is free; writes always can.
  assign elig0 = m0.req && (m0.wr || !fifo_full);
  assign elig1 = m1.req && (m1.wr || !fifo_full);

`ifdef DATA_ARB_FIXED_PRIO_EN
  always_comb begin
    sel = PORT_CORE;
    if (lock_state == LOCKED)  sel = lock_id;
    else if (elig1 && !elig0)  sel = PORT_AUX;
  end
`else
  port_id_e rr_ptr;

  always_comb begin
    sel = rr_ptr;
    if (lock_state == LOCKED)  sel = lock_id;
    else if (elig0 && !elig1)  sel = PORT_CORE;
    else if (elig1 && !elig0)  sel = PORT_AUX;
  end

  always_ff @(posedge clk) begin
    if (rst)        rr_ptr <= PORT_CORE;
    else if (grant) rr_ptr <= (sel == PORT_CORE) ? PORT_AUX : PORT_CORE;
  end
`endif

  always_comb begin
    mem.req   = (sel == PORT_AUX) ? elig1 : elig0;
    mem.wr    = 1'b0;
    mem.addr  = '0;
    mem.wdata = '0;
    mem.be    = '0;
    if (mem.req) begin
      if (sel == PORT_AUX) begin
        mem.wr = m1.wr; mem.addr = m1.addr; mem.wdata = m1.wdata; mem.be = m1.be;
      end else begin
        mem.wr = m0.wr; mem.addr = m0.addr; mem.wdata = m0.wdata; mem.be = m0.be;
      end
    end
  end

  assign grant    = mem.req && mem.gnt;
  assign push     = grant && !mem.wr;
  assign pop      = mem.rvalid && !fifo_empty;
  assign m0.gnt   = grant && (sel == PORT_CORE);
  assign m1.gnt   = grant && (sel == PORT_AUX);
  assign m0.rvalid = pop && (fifo_head == PORT_CORE);
  assign m1.rvalid = pop && (fifo_head == PORT_AUX);
  assign m0.rdata = mem.rdata;
  assign m1.rdata = mem.rdata;

  // An ungranted request pins the selection so the memory sees stable address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state <= UNLOCKED;
      lock_id    <= PORT_CORE;
    end else begin
      case (lock_state)
        UNLOCKED: if (mem.req && !mem.gnt) begin
          lock_state <= LOCKED;
          lock_id    <= sel;
        end
        LOCKED: if (mem.gnt) lock_state <= UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                           err_o <= 1'b0;
    else if (mem.rvalid && fifo_empty) err_o <= 1'b1;
  end

  assign lock_state_o = lock_state;

  core_data_arb_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (sel),
    .pop     (pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outst_cnt_o)
  );
endmodule

// File: tb/tb_core_data_arbiter.sv
// Bench for core_data_arbiter: directed scenarios plus a randomized run against a
// queue-based reference model.
module tb_core_data_arbiter;
  import core_data_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_data_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) m0_bus ();
  core_data_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) m1_bus ();
  core_data_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) mem_bus ();

  logic [$clog2(MO):0] outst_cnt;
  logic                err;
  lock_state_e         lock_state;

  core_data_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_OUTST(MO)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0           (m0_bus),
    .m1           (m1_bus),
    .mem          (mem_bus),
    .outst_cnt_o  (outst_cnt),
    .err_o        (err),
    .lock_state_o (lock_state)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: queue of port IDs awaiting read data, a held (ungranted)
  // winner, the port owed the next tie, and the sticky error.
  logic [0:0]     exp_q[$];
  bit             held_v, held_id, rr_next, exp_err;
  bit             win, e_req, e_wr, e_g0, e_g1, e_rv0, e_rv1;
  logic [AW-1:0]  e_addr;
  logic [DW-1:0]  e_wdata;
  logic [BW-1:0]  e_be;
  logic [DW-1:0]  rd_val;

  function automatic void model_reset();
    exp_q.delete();
    held_v = 0; held_id = 0; rr_next = 0; exp_err = 0;
  endfunction

  function automatic void model_eval();
    bit el0, el1;
    el0 = m0_bus.req && (m0_bus.wr || exp_q.size() < MO);
    el1 = m1_bus.req && (m1_bus.wr || exp_q.size() < MO);
    if (held_v)          win = held_id;
    else if (el0 != el1) win = el1;
`ifdef DATA_ARB_FIXED_PRIO_EN
    else                 win = 0;
`else
    else                 win = rr_next;
`endif
    e_req   = win ? el1 : el0;
    e_wr    = e_req ? (win ? m1_bus.wr    : m0_bus.wr)    : 1'b0;
    e_addr  = e_req ? (win ? m1_bus.addr  : m0_bus.addr)  : '0;
    e_wdata = e_req ? (win ? m1_bus.wdata : m0_bus.wdata) : '0;
    e_be    = e_req ? (win ? m1_bus.be    : m0_bus.be)    : '0;
    e_g0    = e_req && mem_bus.gnt && !win;
    e_g1    = e_req && mem_bus.gnt && win;
    e_rv0   = mem_bus.rvalid && exp_q.size() > 0 && exp_q[0] == 1'b0;
    e_rv1   = mem_bus.rvalid && exp_q.size() > 0 && exp_q[0] == 1'b1;
  endfunction

  function automatic void model_update();
    if (mem_bus.rvalid) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      else                  exp_err = 1;
    end
    if (e_req && mem_bus.gnt) begin
      rr_next = !win;
      if (!e_wr) exp_q.push_back(win);
    end
    if (mem_bus.gnt)  held_v = 0;
    else if (e_req) begin held_v = 1; held_id = win; end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    m0_bus.req = 0; m0_bus.wr = 0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.be = '0;
    m1_bus.req = 0; m1_bus.wr = 0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.be = '0;
    mem_bus.gnt = 0; mem_bus.rvalid = 0; mem_bus.rdata = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    checks++; if (mem_bus.req !== 1'b0) $display("FAIL reset_req got=%0b exp=0", mem_bus.req); else passed++;
    checks++; if (mem_bus.addr !== '0) $display("FAIL reset_addr got=%h exp=0", mem_bus.addr); else passed++;
    checks++; if (outst_cnt !== '0) $display("FAIL reset_cnt got=%0d exp=0", outst_cnt); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", err); else passed++;
    checks++; if (lock_state !== UNLOCKED) $display("FAIL reset_lock got=%0d exp=0", lock_state); else passed++;
    checks++; if ({m0_bus.gnt, m1_bus.gnt} !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", {m0_bus.gnt, m1_bus.gnt}); else passed++;
    tick();
  endtask

  task automatic test_single_read();
    int gcount = 0;
    do_reset();
    m0_bus.req = 1; m0_bus.wr = 0; m0_bus.addr = 16'h0040; m0_bus.be = 4'hf;
    mem_bus.gnt = 1;
    #3;
    gcount += int'(m0_bus.gnt);
    checks++; if (mem_bus.addr !== 16'h0040) $display("FAIL single_addr got=%h exp=0040", mem_bus.addr); else passed++;
    checks++; if (outst_cnt !== 0) $display("FAIL single_cnt0 got=%0d exp=0", outst_cnt); else passed++;
    tick();
    m0_bus.req = 0; mem_bus.gnt = 0;
    #3;
    gcount += int'(m0_bus.gnt);
    checks++; if (outst_cnt !== 1) $display("FAIL single_cnt1 got=%0d exp=1", outst_cnt); else passed++;
    checks++; if (m0_bus.rvalid !== 1'b0) $display("FAIL single_early_rv got=%0b exp=0", m0_bus.rvalid); else passed++;
    tick();
    mem_bus.rvalid = 1; mem_bus.rdata = 32'hDEADBEEF;
    #3;
    gcount += int'(m0_bus.gnt);
    checks++; if (m0_bus.rvalid !== 1'b1) $display("FAIL single_rv0 got=%0b exp=1", m0_bus.rvalid); else passed++;
    checks++; if (m1_bus.rvalid !== 1'b0) $display("FAIL single_rv1 got=%0b exp=0", m1_bus.rvalid); else passed++;
    checks++; if (m0_bus.rdata !== 32'hDEADBEEF) $display("FAIL single_rdata got=%h exp=deadbeef", m0_bus.rdata); else passed++;
    tick();
    mem_bus.rvalid = 0;
    #3;
    gcount += int'(m0_bus.gnt);
    checks++; if (outst_cnt !== 0) $display("FAIL single_cnt2 got=%0d exp=0", outst_cnt); else passed++;
    checks++; if (gcount != 1) $display("FAIL single_gnt_count got=%0d exp=1", gcount); else passed++;
    tick();
  endtask

  task automatic test_round_robin();
    bit exp_g0, exp_rv0;
    do_reset();
    m0_bus.req = 1; m0_bus.wr = 0; m0_bus.addr = 16'h0010; m0_bus.be = 4'hf;
    m1_bus.req = 1; m1_bus.wr = 0; m1_bus.addr = 16'h0020; m1_bus.be = 4'h3;
    mem_bus.gnt = 1;
    for (int i = 0; i < 8; i++) begin
      mem_bus.rvalid = (i > 0);
      mem_bus.rdata  = DW'(i);
`ifdef DATA_ARB_FIXED_PRIO_EN
      exp_g0 = 1; exp_rv0 = 1;
`else
      exp_g0 = (i % 2 == 0); exp_rv0 = ((i - 1) % 2 == 0);
`endif
      #3;
      checks++; if (m0_bus.gnt !== exp_g0) $display("FAIL rr_gnt0 i=%0d got=%0b exp=%0b", i, m0_bus.gnt, exp_g0); else passed++;
      checks++; if (m1_bus.gnt !== !exp_g0) $display("FAIL rr_gnt1 i=%0d got=%0b exp=%0b", i, m1_bus.gnt, !exp_g0); else passed++;
      if (i > 0) begin
        checks++; if (m0_bus.rvalid !== exp_rv0) $display("FAIL rr_rv0 i=%0d got=%0b exp=%0b", i, m0_bus.rvalid, exp_rv0); else passed++;
        checks++; if (m1_bus.rvalid !== !exp_rv0) $display("FAIL rr_rv1 i=%0d got=%0b exp=%0b", i, m1_bus.rvalid, !exp_rv0); else passed++;
      end
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_lock_stable();
    do_reset();
    m1_bus.req = 1; m1_bus.wr = 1; m1_bus.addr = 16'h0100; m1_bus.wdata = 32'h12345678; m1_bus.be = 4'hf;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        m0_bus.req = 1; m0_bus.wr = 0; m0_bus.addr = 16'h0200; m0_bus.be = 4'hf;
      end
      mem_bus.gnt = (i == 3);
      #3;
      checks++; if (mem_bus.addr !== 16'h0100) $display("FAIL lock_addr i=%0d got=%h exp=0100", i, mem_bus.addr); else passed++;
      checks++; if (mem_bus.wdata !== 32'h12345678) $display("FAIL lock_wdata i=%0d got=%h exp=12345678", i, mem_bus.wdata); else passed++;
      checks++; if (m1_bus.gnt !== (i == 3)) $display("FAIL lock_gnt1 i=%0d got=%0b exp=%0b", i, m1_bus.gnt, (i == 3)); else passed++;
      checks++; if (m0_bus.gnt !== 1'b0) $display("FAIL lock_gnt0 i=%0d got=%0b exp=0", i, m0_bus.gnt); else passed++;
      tick();
    end
    m1_bus.req = 0;
    #3;
    checks++; if (m0_bus.gnt !== 1'b1) $display("FAIL lock_next_gnt0 got=%0b exp=1", m0_bus.gnt); else passed++;
    checks++; if (mem_bus.addr !== 16'h0200) $display("FAIL lock_next_addr got=%h exp=0200", mem_bus.addr); else passed++;
    tick();
    drive_idle();
  endtask

  task automatic test_full_block();
    do_reset();
    m0_bus.req = 1; m0_bus.wr = 0; m0_bus.addr = 16'h0300; m0_bus.be = 4'hf;
    mem_bus.gnt = 1;
    for (int i = 0; i < 2; i++) begin
      #3;
      checks++; if (m0_bus.gnt !== 1'b1) $display("FAIL full_fill_gnt i=%0d got=%0b exp=1", i, m0_bus.gnt); else passed++;
      tick();
    end
    #3;
    checks++; if (outst_cnt !== 2) $display("FAIL full_cnt got=%0d exp=2", outst_cnt); else passed++;
    checks++; if (mem_bus.req !== 1'b0) $display("FAIL full_req got=%0b exp=0", mem_bus.req); else passed++;
    tick();
    m1_bus.req = 1; m1_bus.wr = 1; m1_bus.addr = 16'h0400; m1_bus.wdata = 32'hCAFE0001; m1_bus.be = 4'h1;
    #3;
    checks++; if (m1_bus.gnt !== 1'b1) $display("FAIL full_wr_gnt got=%0b exp=1", m1_bus.gnt); else passed++;
    checks++; if (m0_bus.gnt !== 1'b0) $display("FAIL full_rd_gnt got=%0b exp=0", m0_bus.gnt); else passed++;
    checks++; if (mem_bus.addr !== 16'h0400) $display("FAIL full_wr_addr got=%h exp=0400", mem_bus.addr); else passed++;
    tick();
    m1_bus.req = 0; mem_bus.rvalid = 1; mem_bus.rdata = 32'h0BADF00D;
    #3;
    checks++; if (m0_bus.rvalid !== 1'b1) $display("FAIL full_pop_rv got=%0b exp=1", m0_bus.rvalid); else passed++;
    checks++; if (mem_bus.req !== 1'b0) $display("FAIL full_pop_req got=%0b exp=0", mem_bus.req); else passed++;
    tick();
    mem_bus.rvalid = 0;
    #3;
    checks++; if (outst_cnt !== 1) $display("FAIL full_after_cnt got=%0d exp=1", outst_cnt); else passed++;
    checks++; if (m0_bus.gnt !== 1'b1) $display("FAIL full_reissue_gnt got=%0b exp=1", m0_bus.gnt); else passed++;
    checks++; if (mem_bus.addr !== 16'h0300) $display("FAIL full_reissue_addr got=%h exp=0300", mem_bus.addr); else passed++;
    tick();
    drive_idle();
  endtask

  task automatic test_err();
    do_reset();
    mem_bus.rvalid = 1; mem_bus.rdata = 32'h11111111;
    #3;
    checks++; if ({m0_bus.rvalid, m1_bus.rvalid} !== 2'b00) $display("FAIL err_rv got=%b exp=00", {m0_bus.rvalid, m1_bus.rvalid}); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL err_pre got=%0b exp=0", err); else passed++;
    tick();
    mem_bus.rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++; if (err !== 1'b1) $display("FAIL err_sticky i=%0d got=%0b exp=1", i, err); else passed++;
      tick();
    end
    do_reset();
    #3;
    checks++; if (err !== 1'b0) $display("FAIL err_clear got=%0b exp=0", err); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_bus.req = 1; m0_bus.wr = 0; m0_bus.addr = 16'h0500; m0_bus.be = 4'hf;
    mem_bus.gnt = 1;
    tick();
    tick();
    m0_bus.req = 0; mem_bus.gnt = 0;
    m1_bus.req = 1; m1_bus.wr = 1; m1_bus.addr = 16'h0600; m1_bus.wdata = 32'h5; m1_bus.be = 4'hf;
    #3;
    checks++; if (outst_cnt !== 2) $display("FAIL rstmid_cnt got=%0d exp=2", outst_cnt); else passed++;
    tick();
    #3;
    checks++; if (lock_state !== LOCKED) $display("FAIL rstmid_locked got=%0d exp=1", lock_state); else passed++;
    drive_idle();
    rst = 1;
    tick();
    rst = 0;
    #3;
    checks++; if (outst_cnt !== 0) $display("FAIL rstmid_cnt_clr got=%0d exp=0", outst_cnt); else passed++;
    checks++; if (lock_state !== UNLOCKED) $display("FAIL rstmid_unlock got=%0d exp=0", lock_state); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL rstmid_err0 got=%0b exp=0", err); else passed++;
    tick();
    mem_bus.rvalid = 1;
    #3;
    checks++; if (m0_bus.rvalid !== 1'b0) $display("FAIL rstmid_stray_rv got=%0b exp=0", m0_bus.rvalid); else passed++;
    tick();
    mem_bus.rvalid = 0;
    #3;
    checks++; if (err !== 1'b1) $display("FAIL rstmid_err1 got=%0b exp=1", err); else passed++;
    tick();
  endtask

  task automatic test_random();
    bit g0, g1;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!m0_bus.req && $urandom_range(0, 1) == 1) begin
        m0_bus.req = 1; m0_bus.wr = ($urandom_range(0, 2) == 0);
        m0_bus.addr = AW'($urandom); m0_bus.wdata = $urandom; m0_bus.be = BW'($urandom);
      end
      if (!m1_bus.req && $urandom_range(0, 1) == 1) begin
        m1_bus.req = 1; m1_bus.wr = ($urandom_range(0, 2) == 0);
        m1_bus.addr = AW'($urandom); m1_bus.wdata = $urandom; m1_bus.be = BW'($urandom);
      end
      mem_bus.gnt    = ($urandom_range(0, 3) != 0);
      mem_bus.rvalid = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      rd_val         = $urandom;
      mem_bus.rdata  = rd_val;
      #3;
      model_eval();
      checks++; if (mem_bus.req !== e_req) $display("FAIL rnd_req cyc=%0d got=%0b exp=%0b", cyc, mem_bus.req, e_req); else passed++;
      checks++; if (mem_bus.wr !== e_wr) $display("FAIL rnd_wr cyc=%0d got=%0b exp=%0b", cyc, mem_bus.wr, e_wr); else passed++;
      checks++; if (mem_bus.addr !== e_addr) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, mem_bus.addr, e_addr); else passed++;
      checks++; if (mem_bus.wdata !== e_wdata) $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_bus.wdata, e_wdata); else passed++;
      checks++; if (mem_bus.be !== e_be) $display("FAIL rnd_be cyc=%0d got=%h exp=%h", cyc, mem_bus.be, e_be); else passed++;
      checks++; if ({m0_bus.gnt, m1_bus.gnt} !== {e_g0, e_g1}) $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, {m0_bus.gnt, m1_bus.gnt}, {e_g0, e_g1}); else passed++;
      checks++; if ({m0_bus.rvalid, m1_bus.rvalid} !== {e_rv0, e_rv1}) $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, {m0_bus.rvalid, m1_bus.rvalid}, {e_rv0, e_rv1}); else passed++;
      checks++; if (m1_bus.rdata !== rd_val) $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, m1_bus.rdata, rd_val); else passed++;
      checks++; if (outst_cnt !== exp_q.size()) $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, outst_cnt, exp_q.size()); else passed++;
      checks++; if (err !== exp_err) $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", cyc, err, exp_err); else passed++;
      g0 = e_g0; g1 = e_g1;
      model_update();
      tick();
      if (g0) m0_bus.req = 0;
      if (g1) m1_bus.req = 0;
    end
    drive_idle();
    tick();
  endtask

  initial begin
    rst = 1;
    drive_idle();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock_stable();
    test_full_block();
    test_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/core_data_arbiter.md
Name: core_data_arbiter

Overview:
- Shares the single data-memory port (req/gnt/rvalid protocol) between two requesters: port 0 is the core memory stage, port 1 is a secondary master (debug/DMA).
- Arbitrates each request and holds the selection stable until it is granted.
- Tracks outstanding reads in order so each data_rvalid_i/data_rdata_i beat is routed back to the port that issued the read.
- Sits between core_mem_stage (and the secondary master) and the data RAM/bus.

Parameters:
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 32, data width
BE_WIDTH, 4, byte-enable width
MAX_OUTST, 2, maximum in-flight reads (power of 2, >=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m0_req_i / m1_req_i  in  1  request, held until granted
m0_wr_i / m1_wr_i  in  1  1=write, 0=read
m0_addr_i / m1_addr_i  in  ADDR_WIDTH  address
m0_wdata_i / m1_wdata_i  in  DATA_WIDTH  write data
m0_be_i / m1_be_i  in  BE_WIDTH  byte enables
m0_gnt_o / m1_gnt_o  out  1  request accepted this cycle
m0_rvalid_o / m1_rvalid_o  out  1  read data valid for this port
m_rdata_o  out  DATA_WIDTH  read data, broadcast to both ports
data_req_o  out  1  memory request
data_wr_o  out  1  memory write
data_addr_o  out  ADDR_WIDTH  memory address
data_wdata_o  out  DATA_WIDTH  memory write data
data_be_o  out  BE_WIDTH  memory byte enables
data_gnt_i  in  1  memory grant
data_rvalid_i  in  1  memory read response valid (in order, >=1 cycle after gnt)
data_rdata_i  in  DATA_WIDTH  memory read data
outst_cnt_o  out  $clog2(MAX_OUTST)+1  in-flight read count
err_o  out  1  sticky: rvalid received with no outstanding read

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset: lock cleared, rr pointer=0, FIFO empty, outst_cnt_o=0, err_o=0. Combinational outputs are 0 while no request is pending.
- Reset mid-operation discards in-flight reads. Late rvalids arriving after reset set err_o.
- Eligibility: port X is eligible when mX_req_i && (mX_wr_i || !full). full = (count==MAX_OUTST).
- Selection order:
  - If lock_v, sel=lock_id, provided that port is still eligible.
  - Otherwise, if only one port is eligible, sel=that port.
  - If both are eligible, sel=rr_ptr.
- data_req_o = selected port eligible. Address, write data, byte enables and wr are muxed from sel. All non-req memory outputs are 0 when data_req_o=0.
- mX_gnt_o = data_req_o && data_gnt_i && sel==X. The path is combinational with zero added latency.
- Lock FSM, states UNLOCKED and LOCKED(id):
  - UNLOCKED→LOCKED(sel) when data_req_o && !data_gnt_i.
  - LOCKED→UNLOCKED on data_gnt_i.
  - While LOCKED the selection never switches, so the memory sees stable address and data.
- rr_ptr: on a grant to X, rr_ptr <= ~X.
- Read-tracking FIFO (depth MAX_OUTST, 1-bit entries):
  - Push sel on a read grant. Pop on data_rvalid_i.
  - Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo MAX_OUTST.
- Response routing: mX_rvalid_o = data_rvalid_i && !empty && head==X. m_rdata_o = data_rdata_i. Both are combinational.
- data_rvalid_i while empty: no port rvalid, no pop, err_o<=1 (held until reset).
- Writes: never enter the FIFO; no response is expected. A write is still granted when the FIFO is full.
- Full + read selected under lock: data_req_o drops. The lock is held; the request is re-issued once a pop frees a slot.
- A requester dropping mX_req_i before its grant is a protocol violation; the outcome is undefined.

Optional Feature:
- Macro: DATA_ARB_FIXED_PRIO_EN.
- Defined: when unlocked and both ports are eligible, port 0 (core) always wins; rr_ptr is not implemented.
- Undefined: round-robin as above.
- Lock, FIFO and err_o behaviour are identical in both builds.

Decomposition:
- Shared package: MAX_OUTST default, port-ID encoding (PORT_CORE=0, PORT_AUX=1), lock-state encoding.
- Sub-module: core_data_arb_fifo, the parameterised 1-bit-wide in-order ID FIFO with full/empty/count.
- Arbitration, lock and muxing stay in the top module.

Test Plan:
- Port 0 read addr 0x0040; gnt same cycle; rvalid 2 cycles later with data 0xDEADBEEF → m0_gnt_o=1 once, m0_rvalid_o=1, m_rdata_o=0xDEADBEEF, m1_rvalid_o=0, outst_cnt_o 0→1→0.
- Both ports request reads every cycle, gnt always 1, rvalid 1 cycle later → grants alternate 0,1,0,1. Responses route in the same order. With DATA_ARB_FIXED_PRIO_EN, every grant goes to port 0 while it requests.
- Port 1 write 0x0100/0x12345678, gnt withheld 3 cycles while port 0 starts requesting → data_addr_o stays 0x0100 all 4 cycles; m1_gnt_o on cycle 4; port 0 granted next.
- MAX_OUTST=2, two reads granted, no rvalid → third read: data_req_o=0. A concurrent port 1 write is granted. After one rvalid, the read is issued.
- data_rvalid_i pulse with FIFO empty → no port rvalid, err_o=1 and stays 1 until rst.
- rst asserted with 2 reads outstanding → next cycle outst_cnt_o=0, no lock. A following stray rvalid sets err_o.
